// File: rtl/led_string_serializer.sv
// WS2812-style one-wire serializer: takes one colour word per LED over
// valid/ready and drives the NRZ waveform on led_sdi, then a latch gap.
// Ports: clk, reset (sync, active-high), pixel_data/valid/ready,
// string_active, underrun (1-cycle pulse), led_sdi (registered).
// Optional macro LED_STRING_SERIALIZER_FRAME_CNT_EN adds frame_count[15:0].
module led_string_serializer #(
  parameter int BITS_PER_PIXEL    = 24,
  parameter int N_LEDS_PER_STRING = 236,
  parameter int T0H_CYCLES        = 8,
  parameter int T1H_CYCLES        = 16,
  parameter int BIT_CYCLES        = 25,
  parameter int LATCH_CYCLES      = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      string_active,
  output logic                      underrun,
`ifdef LED_STRING_SERIALIZER_FRAME_CNT_EN
  output logic [15:0]               frame_count,
`endif
  output logic                      led_sdi
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam int BW = $clog2(BITS_PER_PIXEL + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H_C    = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H_CYCLES);
  localparam logic [BW-1:0] BIT_TOP  = BW'(BITS_PER_PIXEL - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [15:0]   LED_LAST = 16'(N_LEDS_PER_STRING - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                    state, state_n;
  logic [BITS_PER_PIXEL-1:0] shreg, shreg_n;
  logic [15:0]               led_cnt, led_cnt_n;
  logic [BW-1:0]             bit_idx, bit_idx_n;
  logic [CW-1:0]             cyc, cyc_n;
  logic [LW-1:0]             lat_cnt, lat_cnt_n;
  logic                      aborted, aborted_n;
  logic                      sdi_n;
  logic                      ready_c;
  logic                      urun_c;
  logic                      lat_done;

  // Current bit always sits in the shift register MSB; bit_idx only
  // tracks how many bits of the pixel remain.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    led_cnt_n = led_cnt;
    bit_idx_n = bit_idx;
    cyc_n     = cyc;
    lat_cnt_n = lat_cnt;
    aborted_n = aborted;
    ready_c   = 1'b0;
    urun_c    = 1'b0;
    lat_done  = 1'b0;
    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (pixel_valid) begin
          state_n   = SHIFT;
          shreg_n   = pixel_data;
          led_cnt_n = '0;
          bit_idx_n = BIT_TOP;
          cyc_n     = '0;
        end
      end
      SHIFT: begin
        if (cyc != CYC_LAST) begin
          cyc_n = cyc + 1'b1;
        end else if (bit_idx != '0) begin
          cyc_n     = '0;
          bit_idx_n = bit_idx - 1'b1;
          shreg_n   = shreg << 1;
        end else if (led_cnt == LED_LAST) begin
          state_n   = LATCH;
          lat_cnt_n = '0;
          aborted_n = 1'b0;
        end else begin
          ready_c = 1'b1;
          if (pixel_valid) begin
            shreg_n   = pixel_data;
            led_cnt_n = led_cnt + 16'd1;
            bit_idx_n = BIT_TOP;
            cyc_n     = '0;
          end else begin
            urun_c    = 1'b1;
            state_n   = LATCH;
            lat_cnt_n = '0;
            aborted_n = 1'b1;
          end
        end
      end
      LATCH: begin
        if (lat_cnt == LAT_LAST) begin
          state_n  = IDLE;
          lat_done = 1'b1;
        end else begin
          lat_cnt_n = lat_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Output is computed from the next-cycle position so the registered
    // pin lines up with the state it describes.
    sdi_n = (state_n == SHIFT) &&
            (cyc_n < (shreg_n[BITS_PER_PIXEL-1] ? T1H_C : T0H_C));
  end

  assign pixel_ready = ready_c & ~reset;
  assign underrun    = urun_c & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      led_cnt       <= '0;
      bit_idx       <= '0;
      cyc           <= '0;
      lat_cnt       <= '0;
      aborted       <= 1'b0;
      led_sdi       <= 1'b0;
      string_active <= 1'b0;
    end else begin
      state         <= state_n;
      shreg         <= shreg_n;
      led_cnt       <= led_cnt_n;
      bit_idx       <= bit_idx_n;
      cyc           <= cyc_n;
      lat_cnt       <= lat_cnt_n;
      aborted       <= aborted_n;
      led_sdi       <= sdi_n;
      string_active <= (state_n != IDLE);
    end
  end

`ifdef LED_STRING_SERIALIZER_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (lat_done && !aborted) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_led_string_serializer.sv
// Scoreboard bench for led_string_serializer: random frames, per-cycle
// expected pin timeline built from the waveform rules.
module tb_led_string_serializer;

  localparam int N   = 3;
  localparam int BC  = 25;
  localparam int PIX = 24 * BC;
  localparam int LAT = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic        string_active;
  logic        underrun;
  logic        led_sdi;
`ifdef LED_STRING_SERIALIZER_FRAME_CNT_EN
  logic [15:0] frame_count;
  logic [15:0] fc_model = '0;
`endif

  led_string_serializer #(
    .N_LEDS_PER_STRING(N)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_data   (pixel_data),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .string_active(string_active),
    .underrun     (underrun),
`ifdef LED_STRING_SERIALIZER_FRAME_CNT_EN
    .frame_count  (frame_count),
`endif
    .led_sdi      (led_sdi)
  );

  always #25 clk = ~clk;

  // {led_sdi, string_active, pixel_ready, underrun} per cycle
  logic [3:0] expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic rst_q = 1'b1;

  always @(posedge clk) rst_q <= reset;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] act;
    logic [3:0] exp;
    act = {led_sdi, string_active, pixel_ready, underrun};
    if (reset) begin
      if (rst_q) check("reset_state", 16'(act), 16'h0);
      else check("reset_ready", 16'(pixel_ready), 16'h0);
    end else begin
      exp = (expq.size() != 0) ? expq.pop_front() : 4'b0010;
      check("pins sdi/act/rdy/urun", 16'(act), 16'(exp));
    end
  end

  // Called at posedge+1 of an idle cycle; k < N means underrun after k.
  task automatic run_frame(input int k, input logic [23:0] px [3],
                           input int abort_t);
    expq.push_back(4'b0010);
    for (int i = 0; i < k; i++) begin
      for (int off = 0; off < PIX; off++) begin
        int b;
        int c;
        logic s;
        logic last;
        b = off / BC;
        c = off % BC;
        last = (off == PIX - 1);
        s = (c < (px[i][23-b] ? 16 : 8));
        expq.push_back({s, 1'b1, last && (i < N - 1),
                        last && (i == k - 1) && (k < N)});
      end
    end
    repeat (LAT) expq.push_back(4'b0100);
    for (int t = 0; t <= PIX * k + LAT; t++) begin
      if (t == abort_t) begin
        reset = 1'b1;
        pixel_valid = 1'b0;
        expq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef LED_STRING_SERIALIZER_FRAME_CNT_EN
        fc_model = '0;
`endif
        return;
      end
      if ((t % PIX == 0) && (t / PIX < k)) begin
        pixel_valid = 1'b1;
        pixel_data = px[t/PIX];
      end else if (t == PIX * k && k < N) begin
        pixel_valid = 1'b0;
        pixel_data = 24'($urandom);
      end else begin
        pixel_valid = 1'($urandom_range(0, 1));
        pixel_data = 24'($urandom);
      end
      @(posedge clk);
      #1;
    end
    pixel_valid = 1'b0;
`ifdef LED_STRING_SERIALIZER_FRAME_CNT_EN
    if (k == N) fc_model = fc_model + 16'd1;
    check("frame_count", frame_count, fc_model);
`endif
  endtask

  task automatic gap(input int g);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [23:0] px [3];
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    gap(2);

    px[0] = 24'hFFFFFF; px[1] = 24'h000000; px[2] = 24'hAAAAAA;
    run_frame(3, px, -1);
    gap(3);

    px[0] = 24'h800000; px[1] = 24'h0; px[2] = 24'h0;
    run_frame(1, px, -1);
    gap(1);

    for (int i = 0; i < 3; i++) px[i] = 24'($urandom);
    run_frame(3, px, 1 + PIX + 5 * BC + 2);
    for (int i = 0; i < 3; i++) px[i] = 24'($urandom);
    run_frame(3, px, -1);

    for (int f = 0; f < 8; f++) begin
      gap($urandom_range(0, 4));
      for (int i = 0; i < 3; i++) px[i] = 24'($urandom);
      run_frame($urandom_range(1, 3), px, -1);
    end

`ifdef LED_STRING_SERIALIZER_FRAME_CNT_EN
    force dut.frame_count = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_count;
    fc_model = 16'hFFFF;
    for (int i = 0; i < 3; i++) px[i] = 24'($urandom);
    run_frame(3, px, -1);
`endif

    gap(3);
    check("queue_drained", 16'(expq.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_string_serializer.md
Name: led_string_serializer

Overview:
- Per-string WS2812-style serializer in the clk_20 domain, downstream of the pixel FIFO / string scheduler.
- Accepts one packed colour word per LED over a valid/ready handshake and emits the one-wire NRZ waveform on led_sdi.
- Counts LEDs per frame and inserts the latch (reset) gap after the last LED or on underrun.
- Instantiated once per color or white string by the string driver modules.

Parameters:
- BITS_PER_PIXEL, 24: bits shifted per LED, MSB first.
- N_LEDS_PER_STRING, 236: pixels per frame (1..65535).
- T0H_CYCLES, 8: high time of a '0' bit in clk cycles (400 ns at 20 MHz).
- T1H_CYCLES, 16: high time of a '1' bit (800 ns).
- BIT_CYCLES, 25: total bit period (1.25 us); must exceed T1H_CYCLES.
- LATCH_CYCLES, 1000: low time after a frame (50 us).

Ports:
- clk  in  1  clk_20 system clock; sole clock of the block.
- reset  in  1  synchronous, active-high reset.
- pixel_data  in  BITS_PER_PIXEL  colour word for the next LED.
- pixel_valid  in  1  pixel_data valid.
- pixel_ready  out  1  block accepts pixel_data this cycle; transfer occurs when valid and ready are both high.
- string_active  out  1  high while a frame or latch is in progress.
- underrun  out  1  one-cycle pulse when a pixel was due mid-frame and none was valid.
- led_sdi  out  1  registered serial data to the LED string.

Behaviour:
- Reset values: led_sdi=0, string_active=0, underrun=0. pixel_ready=0 while reset is high. All counters are 0 and the state is IDLE.
- Reset mid-frame: led_sdi is 0 on the next edge. The partial frame is abandoned and no latch gap is enforced; the downstream LEDs see a long low.
- States:
  - IDLE: led_sdi=0, pixel_ready=1. On transfer, load the shift register, set led_count=0, bit_idx=BITS_PER_PIXEL-1, cyc=0, and go to SHIFT.
  - SHIFT: led_sdi=1 while cyc < (current bit ? T1H_CYCLES : T0H_CYCLES), else 0. cyc runs 0..BIT_CYCLES-1. At wrap, bit_idx decrements.
  - LATCH: led_sdi=0 and the latch counter runs 0..LATCH_CYCLES-1, then the state returns to IDLE. pixel_ready=0 throughout.
- Latency: when a transfer occurs in cycle N, led_sdi rises in cycle N+1. For a '1' MSB, led_sdi stays high for exactly T1H_CYCLES.
- Back-to-back pixels:
  - In SHIFT, pixel_ready=1 only in the final cycle (cyc=BIT_CYCLES-1, bit_idx=0) of a non-last LED (led_count < N_LEDS_PER_STRING-1).
  - A transfer in that cycle starts the next pixel's MSB in the following cycle, with no gap. led_count increments.
- End of frame: in the final cycle of the last LED's last bit, the state goes to LATCH.
- Underrun: in the final cycle of a non-last LED with pixel_valid=0:
  - underrun pulses for 1 cycle;
  - the state goes to LATCH and the frame is aborted;
  - the next accepted pixel restarts at LED 0.
- string_active = (state != IDLE), registered alongside the state.
- pixel_valid is ignored whenever pixel_ready=0. pixel_data is not required to be stable outside transfer cycles.
- led_count is 16 bits wide and cannot wrap, because N_LEDS_PER_STRING ≤ 65535.

Optional Feature:
- Macro: LED_STRING_SERIALIZER_FRAME_CNT_EN.
- When defined: adds the port frame_count out 16, reset 0.
  - Increments by 1 in the cycle LATCH completes after a full frame.
  - Aborted (underrun) frames do not count.
  - Wraps from 0xFFFF to 0x0000.
- When undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Reset/idle:
  - With reset high, check led_sdi=0, pixel_ready=0, string_active=0.
  - One cycle after release, check pixel_ready=1 and led_sdi=0.
- Single bit timing (defaults, N_LEDS_PER_STRING=1):
  - Send pixel 0x800000.
  - Check led_sdi high 16 cycles and low 9 for the first bit, then 23× (8 high, 17 low).
  - Then check 1000 low cycles in LATCH, followed by pixel_ready=1.
- Back-to-back (N_LEDS_PER_STRING=3, pixel_valid held high):
  - Send 0xFFFFFF, 0x000000, 0xAAAAAA.
  - Check 72 contiguous bit periods with no extra cycles between pixels, then LATCH.
  - Check pixel_ready pulses exactly twice in SHIFT.
- Underrun (N_LEDS_PER_STRING=3):
  - Supply 1 pixel, then drop valid.
  - Check underrun is a 1-cycle pulse at cycle 600 after acceptance, followed by 1000 low cycles.
  - The next pixel restarts the frame and is followed by 3 LEDs before LATCH.
- Reset mid-frame:
  - Assert reset during bit 5 of LED 1, while led_sdi is high.
  - Check led_sdi=0 and string_active=0 on the next edge, and a fresh frame is accepted after release.
- With LED_STRING_SERIALIZER_FRAME_CNT_EN (N_LEDS_PER_STRING=2):
  - Run 2 complete frames and check frame_count=2.
  - Run 1 underrun frame and check frame_count stays 2.
  - Force the counter to 0xFFFF, complete one frame, and check frame_count=0x0000.
